// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two-requester round-robin arbiter that feeds one UART transmitter through a txif handshake. Optional watchdog under UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int TO_WIDTH = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [31:0] req0_data,
  input  logic [31:0] req1_data,
  input  logic [1:0]  req0_ctrl,
  input  logic [1:0]  req1_ctrl,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic        txif,
  output logic        tx_enable,
  output logic [31:0] tx_data,
  output logic [1:0]  tx_control,
  output logic [1:0]  grant,
  output logic        busy
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic        err,
  input  logic        err_clr
`endif
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH} state_t;
  state_t state;
  logic   last;
  logic   pick1;
  logic   accept;
  logic   timeout;
  if (TO_WIDTH < 2) begin : g_width_check
    $error("TO_WIDTH must be at least 2");
  end
  // Arbitration is combinational so the winner's ready pulses in the accept cycle; a tie goes to whoever was not granted last.
  always_comb begin
    pick1  = req1_valid & (~req0_valid | ~last);
    accept = ~reset & (state == IDLE) & txif & (req0_valid | req1_valid);
  end
  assign req0_ready = accept & ~pick1;
  assign req1_ready = accept & pick1;
  assign busy       = state != IDLE;
`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [TO_WIDTH-1:0] LIM = {TO_WIDTH{1'b1}} - TO_WIDTH'(1);
  logic [TO_WIDTH-1:0] cnt;
  // The watchdog fires on the cycle the counter would reach its all-ones limit while still stuck waiting.
  always_comb timeout = ((state == WAIT_LOW & txif) | (state == WAIT_HIGH & ~txif)) & (cnt == LIM);
  // Counter restarts on entry to each wait state and counts every cycle spent there.
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (state == ISSUE || (state == WAIT_LOW && !txif)) cnt <= '0;
    else if (state == WAIT_LOW || state == WAIT_HIGH) cnt <= cnt + TO_WIDTH'(1);
  end
  // Sticky error flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) err <= 1'b0;
    else if (timeout) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end
`else
  assign timeout = 1'b0;
`endif
  // Transfer FSM: accept and latch in IDLE, strobe once in ISSUE, then follow txif low and back high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tx_enable  <= 1'b0;
      tx_data    <= '0;
      tx_control <= '0;
      grant      <= '0;
      last       <= 1'b1;
    end else begin
      tx_enable <= accept;
      case (state)
        IDLE: if (accept) begin
          state      <= ISSUE;
          tx_data    <= pick1 ? req1_data : req0_data;
          tx_control <= pick1 ? req1_ctrl : req0_ctrl;
          grant      <= pick1 ? 2'b10 : 2'b01;
          last       <= pick1;
        end
        ISSUE: state <= WAIT_LOW;
        WAIT_LOW: if (timeout) begin
          state <= IDLE;
          grant <= '0;
        end else if (!txif) state <= WAIT_HIGH;
        WAIT_HIGH: if (timeout || txif) begin
          state <= IDLE;
          grant <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TO_WIDTH, default 20, width of the timeout counter; the timeout limit is 2^TO_WIDTH-1 cycles.
REQ-002 SHALL have port clk  input  1  single system clock; all logic is on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester N has a word to send.
REQ-005 SHALL have ports req0_data / req1_data  input  32  word from requester N.
REQ-006 SHALL have ports req0_ctrl / req1_ctrl  input  2  uart_control value passed with requester N's word.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1  one-cycle pulse: requester N's word is accepted.
REQ-008 SHALL have port txif  input  1  transmitter status; 1 = transmitter can accept a word.
REQ-009 SHALL have port tx_enable  output  1  one-cycle write strobe to the transmitter.
REQ-010 SHALL have port tx_data  output  32  word presented to the transmitter.
REQ-011 SHALL have port tx_control  output  2  uart_control presented to the transmitter.
REQ-012 SHALL have port grant  output  2  one-hot owner of the current transfer; 00 = none.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port err  output  1  sticky timeout flag; this port exists only under UART_ARB_TIMEOUT_EN.
REQ-015 SHALL have port err_clr  input  1  clears err; this port exists only under UART_ARB_TIMEOUT_EN.

Function
REQ-016 SHALL implement the states IDLE, ISSUE, WAIT_LOW and WAIT_HIGH.
REQ-017 IDLE: when txif=1 and any reqN_valid=1, SHALL in that cycle pulse the selected reqN_ready, latch its data and ctrl into tx_data/tx_control, set grant, and go to ISSUE.
REQ-018 IDLE with txif=0 SHALL accept no request, and all ready outputs SHALL stay 0.
REQ-019 Arbitration SHALL be round-robin with a last-grant register: a single valid requester wins; when both are valid, the requester not granted last wins.
REQ-020 ISSUE SHALL assert tx_enable for exactly one cycle and then go to WAIT_LOW. Latency: a valid accepted in cycle N gives tx_enable in cycle N+1.
REQ-021 WAIT_LOW SHALL wait for txif=0 (word taken by the transmitter), then go to WAIT_HIGH.
REQ-022 WAIT_HIGH SHALL wait for txif=1, then clear grant and go to IDLE; a new accept is possible no earlier than the cycle after IDLE is re-entered.
REQ-023 tx_data and tx_control SHALL hold the latched value from accept until the next accept.
REQ-024 At most one ready SHALL pulse per transfer, and never in two consecutive cycles.
REQ-025 Requester inputs SHALL be ignored outside IDLE; a requester SHALL keep valid and data stable until its ready pulse.
REQ-026 A requester dropping valid before its ready pulse SHALL NOT be granted.
REQ-027 The last-grant register SHALL update only on an accept.

Reset
REQ-028 While reset=1 at a clock edge, the state SHALL go to IDLE, and tx_enable, ready outputs, grant and busy SHALL all be 0.
REQ-029 While reset=1 at a clock edge, tx_data SHALL go to 0, tx_control to 00, the last-grant register to requester 1 (so requester 0 wins the first tie), the timeout counter to 0, and err to 0.
REQ-030 Reset asserted mid-transfer, in any state, SHALL abort the transfer without a further tx_enable or ready pulse.

Configuration
REQ-031 Macro UART_ARB_TIMEOUT_EN SHALL compile the timeout watchdog in; when undefined, WAIT_LOW and WAIT_HIGH wait indefinitely, and the err and err_clr ports are absent.
REQ-032 With UART_ARB_TIMEOUT_EN defined, the counter SHALL clear on entry to WAIT_LOW and WAIT_HIGH and increment each cycle spent in them.
REQ-033 With UART_ARB_TIMEOUT_EN defined, reaching 2^TO_WIDTH-1 SHALL set err, clear grant and return to IDLE.
REQ-034 err SHALL stay set until err_clr=1; if err_clr=1 and a new timeout occur in the same cycle, set SHALL win.
REQ-035 While err=1, arbitration SHALL continue normally.

Verification
REQ-036 Single request: req0_valid=1, data 0xA5A5_0001, ctrl 01, txif=1 -> req0_ready in cycle N, tx_enable in N+1 with tx_data=0xA5A5_0001 and tx_control=01, grant=01 until txif returns high.
REQ-037 Tie after reset: both valid, data 0x11 and 0x22 -> requester 0 served first and requester 1 second; with both still valid, the third grant goes to requester 0.
REQ-038 Transmitter busy: txif=0 with req1_valid=1 -> no ready for 50 cycles; txif goes high -> req1_ready the same cycle.
REQ-039 Reset mid-transfer: reset=1 in WAIT_HIGH -> next cycle busy=0, grant=00, tx_data=0, no tx_enable.
REQ-040 Timeout (macro on, TO_WIDTH=4): txif held 1 after tx_enable -> err=1 after 15 cycles in WAIT_LOW and state returns to IDLE; err_clr=1 for one cycle -> err=0.
REQ-041 Macro off: same stimulus as REQ-040 -> the block stays in WAIT_LOW for 1000 cycles with busy=1.
